// File: rtl/tdc_uart_word_tx_pkg.sv
// Purpose: shared types and constants for the TDC word UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Build option TDC_UART_SYNC_BYTE_EN: prefixes every word with SYNC_BYTE (13 bytes per word).
package tdc_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LOAD,
    SEND,
    DONE
  } state_t;

  localparam int TDC_WORD_W = 90;
  localparam int PAD_W      = 96;
  localparam int NBYTES     = 12;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam logic       UART_START = 1'b0;
  localparam logic       UART_STOP  = 1'b1;

`ifdef TDC_UART_SYNC_BYTE_EN
  // Byte slot 0 carries the sync byte, so data byte k rides in slot k+1.
  localparam int NB_TOTAL = NBYTES + 1;
  localparam int DATA_OFS = 1;
`else
  localparam int NB_TOTAL = NBYTES;
  localparam int DATA_OFS = 0;
`endif

  // Byte k of the padded word, counted from the most significant byte.
  function automatic logic [7:0] word_byte(input logic [PAD_W-1:0] w, input logic [3:0] k);
    logic [PAD_W-1:0] s;
    s = w << {k, 3'b000};
    return s[PAD_W-1 -: 8];
  endfunction

endpackage

// File: rtl/tdc_uart_word_tx_if.sv
// Purpose: buffer-side handshake plus serial line of the TDC word UART transmitter.
// Latency: n/a (wiring only).
// Backpressure: UART_go is a level held until UART_done; one word in flight.
// Signals: UART_go (request), data_input (90-bit word), UART_done (pulse), tx (serial), busy.
// Modports: master = hit buffer / driver side, slave = transmitter side.
interface tdc_uart_word_tx_if;
  import tdc_uart_pkg::*;

  logic                  UART_go;
  logic [TDC_WORD_W-1:0] data_input;
  logic                  UART_done;
  logic                  tx;
  logic                  busy;

  modport master (
    output UART_go,
    output data_input,
    input  UART_done,
    input  tx,
    input  busy
  );

  modport slave (
    input  UART_go,
    input  data_input,
    output UART_done,
    output tx,
    output busy
  );

endinterface

// File: rtl/tdc_uart_word_tx_byte.sv
// Purpose: 8N1 UART byte shifter with built-in baud counter.
// Latency: tx start bit appears the cycle after start; frame is 10*CLKS_PER_BIT cycles.
// Backpressure: start is taken only when idle or in the done cycle; otherwise ignored.
// Ports: clk, reset (sync, active-high), start, din[7:0] in; tx, busy, done out.
// done pulses in the last cycle of the stop bit so a start in that same cycle
// puts the next start bit directly behind this stop bit.
module uart_tx_byte
  import tdc_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] din,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  logic        busy_q, busy_d;
  logic        tx_q, tx_d;
  logic [15:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;   // 0 start, 1..8 data, 9 stop
  logic [7:0]  data_q, data_d;
  logic        bit_end;
  logic        frame_end;

  always_comb begin
    busy_d    = busy_q;
    tx_d      = tx_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    data_d    = data_q;
    bit_end   = busy_q && (baud_q == BAUD_LAST);
    frame_end = bit_end && (bit_q == 4'd9);

    if (bit_end) begin
      baud_d = '0;
      if (frame_end) begin
        busy_d = 1'b0;
        tx_d   = UART_STOP;   // idle line level equals stop level
        bit_d  = '0;
      end else begin
        bit_d = bit_q + 4'd1;
        if (bit_q == 4'd8) begin
          tx_d = UART_STOP;
        end else begin
          // LSB first: shift the next data bit out of the bottom
          tx_d   = data_q[0];
          data_d = {1'b0, data_q[7:1]};
        end
      end
    end else if (busy_q) begin
      baud_d = baud_q + 16'd1;
    end

    if (start && (!busy_q || frame_end)) begin
      busy_d = 1'b1;
      tx_d   = UART_START;
      baud_d = '0;
      bit_d  = '0;
      data_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      tx_q   <= UART_STOP;
      baud_q <= '0;
      bit_q  <= '0;
      data_q <= '0;
    end else begin
      busy_q <= busy_d;
      tx_q   <= tx_d;
      baud_q <= baud_d;
      bit_q  <= bit_d;
      data_q <= data_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = frame_end;

endmodule

// File: rtl/tdc_uart_word_tx.sv
// Purpose: serialise one 90-bit TDC word as 12 UART bytes (MSB byte first) per UART_go/UART_done.
// Latency: UART_go rise to UART_done = 1 + CAP_DLY + 1 + 120*CLKS_PER_BIT cycles (130* with sync byte).
// Backpressure: one word in flight; new requests need a fresh UART_go rising edge while idle.
// Ports: clk, reset (sync, active-high); bus (slave modport: UART_go, data_input, UART_done, tx, busy).
// Build option TDC_UART_SYNC_BYTE_EN: send SYNC_BYTE ahead of byte 0 of every word.
module tdc_uart_word_tx
  import tdc_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int CAP_DLY      = 2
) (
  input  logic                clk,
  input  logic                reset,
  tdc_uart_word_tx_if.slave   bus
);

  localparam logic [2:0] CAP_LAST = 3'(CAP_DLY - 1);
  localparam logic [3:0] LAST_IDX = 4'(NB_TOTAL - 1);
  localparam logic [3:0] OFS      = 4'(DATA_OFS);

  state_t           state_q, state_d;
  logic             go_q;
  logic [2:0]       cap_q, cap_d;
  logic [3:0]       idx_q, idx_d;
  logic [PAD_W-1:0] shreg_q, shreg_d;
  logic [PAD_W-1:0] pad_w;
  logic             start_go;
  logic             byte_start;
  logic [7:0]       byte_din;
  logic             byte_tx;
  logic             byte_busy;
  logic             byte_done;

  assign pad_w    = {{(PAD_W - TDC_WORD_W){1'b0}}, bus.data_input};
  assign start_go = bus.UART_go & ~go_q;

  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    byte_start = 1'b0;
    byte_din   = '0;

    case (state_q)
      IDLE: begin
        if (start_go) begin
          state_d = ARM;
          cap_d   = '0;
        end
      end
      // Wait out the buffer read latency before sampling data_input.
      ARM: begin
        if (cap_q == CAP_LAST) begin
          cap_d   = '0;
          state_d = LOAD;
        end else begin
          cap_d = cap_q + 3'd1;
        end
      end
      // Capture the word and launch the first byte straight from the input,
      // so its start bit begins in the first SEND cycle.
      LOAD: begin
        if (!byte_busy) begin
          shreg_d    = pad_w;
          idx_d      = '0;
          byte_start = 1'b1;
`ifdef TDC_UART_SYNC_BYTE_EN
          byte_din   = SYNC_BYTE;
`else
          byte_din   = word_byte(pad_w, 4'd0);
`endif
          state_d    = SEND;
        end
      end
      // idx_q is the slot currently on the line; chain the next one on done.
      SEND: begin
        if (byte_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d      = idx_q + 4'd1;
            byte_start = 1'b1;
            byte_din   = word_byte(shreg_q, idx_q + 4'd1 - OFS);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      go_q    <= 1'b0;
      cap_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      go_q    <= bus.UART_go;
      cap_q   <= cap_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .clk   (clk),
    .reset (reset),
    .start (byte_start),
    .din   (byte_din),
    .tx    (byte_tx),
    .busy  (byte_busy),
    .done  (byte_done)
  );

  assign bus.tx        = byte_tx;
  assign bus.busy      = (state_q != IDLE);
  assign bus.UART_done = (state_q == DONE);

endmodule
